// File: rtl/canny_window_sequencer_if.sv
// ---------------------------------------------------------------------------
// canny_window_sequencer_if
// Bundles the pixel stream, the filtered-pixel stream and the Canny core
// register/operation bus used by canny_window_sequencer.
//   s_valid/s_ready/s_data          : raster input pixel stream
//   m_valid/m_ready/m_data          : filtered pixel stream
//   m_row/m_col                     : centre coordinates of the emitted window
//   dAddrRegRow/dAddrRegCol         : core register address
//   bWE/bCE/bOPEnable               : core write / chip / operation enables (active-low)
//   InData/OutData                  : core write / read data
//   OPMode/dReadReg/dWriteReg       : core operation selectors
// Modport master is the sequencer side; modport slave is the environment
// (pixel source, pixel sink and edge core).
// ---------------------------------------------------------------------------
interface canny_window_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int COORD_W    = 8
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic [COORD_W-1:0]    m_row;
    logic [COORD_W-1:0]    m_col;
    logic [2:0]            dAddrRegRow;
    logic [2:0]            dAddrRegCol;
    logic                  bWE;
    logic                  bCE;
    logic [DATA_WIDTH-1:0] InData;
    logic [DATA_WIDTH-1:0] OutData;
    logic [2:0]            OPMode;
    logic                  bOPEnable;
    logic [3:0]            dReadReg;
    logic [3:0]            dWriteReg;

    modport master (
        input  s_valid, s_data, m_ready, OutData,
        output s_ready, m_valid, m_data, m_row, m_col,
               dAddrRegRow, dAddrRegCol, bWE, bCE, InData,
               OPMode, bOPEnable, dReadReg, dWriteReg
    );

    modport slave (
        output s_valid, s_data, m_ready, OutData,
        input  s_ready, m_valid, m_data, m_row, m_col,
               dAddrRegRow, dAddrRegCol, bWE, bCE, InData,
               OPMode, bOPEnable, dReadReg, dWriteReg
    );
endinterface

// File: rtl/canny_window_sequencer.sv
// ---------------------------------------------------------------------------
// canny_window_sequencer
// Streaming front end for the Canny edge core. Builds 5x5 neighbourhoods
// from a raster pixel stream using four line buffers, loads each complete
// window into the core's regX, runs the Gaussian operation, reads the
// smoothed result back and emits it with the window-centre coordinates.
// Ports:
//   clk   : single rising-edge clock
//   rst_b : asynchronous active-low reset
//   bus   : canny_window_sequencer_if.master (pixel in, pixel out, core bus)
// ---------------------------------------------------------------------------
module canny_window_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 16,
    parameter int IMG_H      = 16,
    parameter int COORD_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst_b,
    canny_window_sequencer_if.master        bus
);
    localparam int COL_AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_OP    = 3'd2,
        S_CLR   = 3'd3,
        S_READ  = 3'd4,
        S_CAPT  = 3'd5,
        S_OUT   = 3'd6
    } state_t;

    state_t                state_q, state_d;
    logic [COORD_W-1:0]    row_q, row_d, col_q, col_d;
    logic [2:0]            wr_row_q, wr_row_d, wr_col_q, wr_col_d;
    logic                  s_ready_q, s_ready_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [COORD_W-1:0]    m_row_q, m_row_d, m_col_q, m_col_d;
    logic                  bce_q, bce_d, bwe_q, bwe_d, bope_q, bope_d;
    logic [2:0]            addr_row_q, addr_row_d, addr_col_q, addr_col_d;
    logic [DATA_WIDTH-1:0] in_data_q, in_data_d;

    logic [DATA_WIDTH-1:0] lb_q  [4][IMG_W];
    logic [DATA_WIDTH-1:0] win_q [5][5];
    logic [DATA_WIDTH-1:0] win_d [5][5];
    logic [DATA_WIDTH-1:0] new_col_s [5];

    logic                  accept_s;
    logic                  win_done_s;
    logic [COL_AW-1:0]     col_idx_s;

    // s_ready_q is only high in IDLE, so an accept implies the FSM is idle.
    assign accept_s   = bus.s_valid && s_ready_q;
    assign win_done_s = (row_q >= COORD_W'(4)) && (col_q >= COORD_W'(4));
    assign col_idx_s  = col_q[COL_AW-1:0];

    // Raster position counters, wrapping at the end of each frame.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept_s) begin
            if (col_q == COORD_W'(IMG_W - 1)) begin
                col_d = COORD_W'(0);
                if (row_q == COORD_W'(IMG_H - 1)) begin
                    row_d = COORD_W'(0);
                end else begin
                    row_d = row_q + COORD_W'(1);
                end
            end else begin
                col_d = col_q + COORD_W'(1);
            end
        end else begin
            row_d = row_q;
            col_d = col_q;
        end
    end

    // Incoming window column (oldest line first) and left-shifted window.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            new_col_s[r] = lb_q[r][col_idx_s];
        end
        new_col_s[4] = bus.s_data;
        win_d = win_q;
        if (accept_s) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 4; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][4] = new_col_s[r];
            end
        end else begin
            win_d = win_q;
        end
    end

    // Line buffers: each column slot shifts up one line per accept.
    // Contents need no reset; every slot is rewritten before a window uses it.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_q[0][col_idx_s] <= lb_q[1][col_idx_s];
            lb_q[1][col_idx_s] <= lb_q[2][col_idx_s];
            lb_q[2][col_idx_s] <= lb_q[3][col_idx_s];
            lb_q[3][col_idx_s] <= bus.s_data;
        end
    end

    // Next-state logic plus registered-output decode from the next state.
    always_comb begin
        state_d  = state_q;
        wr_row_d = wr_row_q;
        wr_col_d = wr_col_q;
        m_data_d = m_data_q;
        m_row_d  = m_row_q;
        m_col_d  = m_col_q;

        case (state_q)
            S_IDLE: begin
                if (accept_s && win_done_s) begin
                    state_d  = S_WRITE;
                    wr_row_d = 3'd0;
                    wr_col_d = 3'd0;
                    m_row_d  = row_q - COORD_W'(2);
                    m_col_d  = col_q - COORD_W'(2);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                if ((wr_row_q == 3'd4) && (wr_col_q == 3'd4)) begin
                    state_d  = S_OP;
                    wr_row_d = 3'd0;
                    wr_col_d = 3'd0;
                end else if (wr_col_q == 3'd4) begin
                    wr_col_d = 3'd0;
                    wr_row_d = wr_row_q + 3'd1;
                end else begin
                    wr_col_d = wr_col_q + 3'd1;
                end
            end
            S_OP: begin
                // wr_col doubles as the two-cycle operation counter.
                if (wr_col_q == 3'd1) begin
                    state_d  = S_CLR;
                    wr_col_d = 3'd0;
                end else begin
                    wr_col_d = wr_col_q + 3'd1;
                end
            end
            S_CLR:  state_d = S_READ;
            S_READ: state_d = S_CAPT;
            S_CAPT: begin
                state_d  = S_OUT;
                m_data_d = bus.OutData;
            end
            S_OUT: begin
                if (bus.m_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_OUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        bce_d      = 1'b1;
        bwe_d      = 1'b1;
        bope_d     = 1'b1;
        addr_row_d = 3'd0;
        addr_col_d = 3'd0;
        in_data_d  = {DATA_WIDTH{1'b0}};
        case (state_d)
            S_WRITE: begin
                bce_d      = 1'b0;
                bwe_d      = 1'b0;
                addr_row_d = wr_row_d;
                addr_col_d = wr_col_d;
                in_data_d  = win_d[wr_row_d][wr_col_d];
            end
            S_OP:    bope_d = 1'b0;
            S_READ:  bce_d  = 1'b0;
            default: bce_d  = 1'b1;
        endcase
        s_ready_d = (state_d == S_IDLE);
        m_valid_d = (state_d == S_OUT);
    end

    // Control, counter and output registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= S_IDLE;
            row_q      <= COORD_W'(0);
            col_q      <= COORD_W'(0);
            wr_row_q   <= 3'd0;
            wr_col_q   <= 3'd0;
            s_ready_q  <= 1'b0;
            m_valid_q  <= 1'b0;
            m_data_q   <= {DATA_WIDTH{1'b0}};
            m_row_q    <= COORD_W'(0);
            m_col_q    <= COORD_W'(0);
            bce_q      <= 1'b1;
            bwe_q      <= 1'b1;
            bope_q     <= 1'b1;
            addr_row_q <= 3'd0;
            addr_col_q <= 3'd0;
            in_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            wr_row_q   <= wr_row_d;
            wr_col_q   <= wr_col_d;
            s_ready_q  <= s_ready_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            m_row_q    <= m_row_d;
            m_col_q    <= m_col_d;
            bce_q      <= bce_d;
            bwe_q      <= bwe_d;
            bope_q     <= bope_d;
            addr_row_q <= addr_row_d;
            addr_col_q <= addr_col_d;
            in_data_q  <= in_data_d;
        end
    end

    // 5x5 window register.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int r = 0; r < 5; r++) begin
                for (int c = 0; c < 5; c++) begin
                    win_q[r][c] <= {DATA_WIDTH{1'b0}};
                end
            end
        end else begin
            win_q <= win_d;
        end
    end

    assign bus.s_ready     = s_ready_q;
    assign bus.m_valid     = m_valid_q;
    assign bus.m_data      = m_data_q;
    assign bus.m_row       = m_row_q;
    assign bus.m_col       = m_col_q;
    assign bus.bCE         = bce_q;
    assign bus.bWE         = bwe_q;
    assign bus.bOPEnable   = bope_q;
    assign bus.dAddrRegRow = addr_row_q;
    assign bus.dAddrRegCol = addr_col_q;
    assign bus.InData      = in_data_q;
    assign bus.OPMode      = 3'd0;
    assign bus.dReadReg    = 4'd0;
    assign bus.dWriteReg   = 4'd0;
endmodule

// File: tb/tb_canny_window_sequencer.sv
// ---------------------------------------------------------------------------
// tb_canny_window_sequencer
// Directed bench for canny_window_sequencer on an 8x8 image, with a small
// behavioural Gaussian edge-core model on the core bus.
// ---------------------------------------------------------------------------
module tb_canny_window_sequencer;
    localparam int DW = 8;
    localparam int CW = 8;
    localparam int W  = 8;
    localparam int H  = 8;

    logic clk = 1'b0;
    logic rst_b;
    always #5 clk = ~clk;

    canny_window_sequencer_if #(.DATA_WIDTH(DW), .COORD_W(CW)) bus_if ();

    canny_window_sequencer #(
        .DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H), .COORD_W(CW)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus_if)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int out_cnt = 0;
    int stall_next = 0;
    bit first_win_chk = 1'b0;
    bit aborted = 1'b0;

    typedef struct {int row; int col; int data; int acc;} exp_t;
    exp_t exp_q[$];

    task automatic chk_eq(input string tag, input int obs, input int exp_v);
        n_chk++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural edge core: regX writes, 5x5 Gaussian (1 4 6 4 1)^2/256, read-back.
    logic [DW-1:0] regx [25];
    int            gauss_q = 0;
    logic [DW-1:0] core_out = 8'd0;
    assign bus_if.OutData = core_out;

    function automatic int gw(input int i);
        case (i)
            0, 4:    return 1;
            1, 3:    return 4;
            default: return 6;
        endcase
    endfunction

    function automatic int gauss5();
        int s = 0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                s += gw(i) * gw(j) * int'(regx[i*5+j]);
        return s / 256;
    endfunction

    always @(posedge clk) begin
        if (!bus_if.bCE && !bus_if.bWE)
            regx[int'(bus_if.dAddrRegRow)*5 + int'(bus_if.dAddrRegCol)] <= bus_if.InData;
        if (!bus_if.bOPEnable) gauss_q <= gauss5();
        if (!bus_if.bCE && bus_if.bWE) core_out <= gauss_q[DW-1:0];
    end

    // Output monitor: checks each result, applies backpressure, drives m_ready.
    initial begin
        bit seen = 1'b0;
        bit hs_prev = 1'b0;
        int stall = 0;
        int h_data = 0, h_row = 0, h_col = 0;
        exp_t e;
        bus_if.m_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                seen = 1'b0; hs_prev = 1'b0; stall = 0;
                bus_if.m_ready = 1'b0;
            end else begin
                if (hs_prev) begin
                    chk_eq("m_valid_drop", int'(bus_if.m_valid), 0);
                    chk_eq("s_ready_after_hs", int'(bus_if.s_ready), 1);
                    hs_prev = 1'b0;
                end
                if (bus_if.m_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        out_cnt++;
                        chk_eq("exp_avail", (exp_q.size() > 0) ? 1 : 0, 1);
                        if (exp_q.size() > 0) begin
                            e = exp_q.pop_front();
                            chk_eq("m_row", int'(bus_if.m_row), e.row);
                            chk_eq("m_col", int'(bus_if.m_col), e.col);
                            chk_eq("m_data", int'(bus_if.m_data), e.data);
                            chk_eq("latency", cyc - e.acc, 31);
                        end
                        h_data = int'(bus_if.m_data);
                        h_row  = int'(bus_if.m_row);
                        h_col  = int'(bus_if.m_col);
                        if (stall_next > 0) begin
                            stall = stall_next;
                            stall_next = 0;
                        end
                    end else begin
                        chk_eq("hold_data", int'(bus_if.m_data), h_data);
                        chk_eq("hold_row", int'(bus_if.m_row), h_row);
                        chk_eq("hold_col", int'(bus_if.m_col), h_col);
                        chk_eq("hold_s_ready", int'(bus_if.s_ready), 0);
                        chk_eq("hold_bCE", int'(bus_if.bCE), 1);
                        chk_eq("hold_bOPEnable", int'(bus_if.bOPEnable), 1);
                    end
                    if (stall > 0) begin
                        bus_if.m_ready = 1'b0;
                        stall--;
                    end else begin
                        bus_if.m_ready = 1'b1;
                        hs_prev = 1'b1;
                        seen = 1'b0;
                    end
                end else begin
                    bus_if.m_ready = 1'b0;
                end
            end
        end
    end

    // Core-bus monitor: burst length of every write, full order of the first ramp window.
    initial begin
        int wk = 0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                wk = 0;
            end else if (!bus_if.bCE && !bus_if.bWE) begin
                if (first_win_chk) begin
                    chk_eq("wr_addr_row", int'(bus_if.dAddrRegRow), wk / 5);
                    chk_eq("wr_addr_col", int'(bus_if.dAddrRegCol), wk % 5);
                    chk_eq("wr_data", int'(bus_if.InData), (wk / 5) * 8 + (wk % 5));
                end
                wk++;
            end else if (wk != 0) begin
                chk_eq("wr_burst_len", wk, 25);
                wk = 0;
                first_win_chk = 1'b0;
            end
        end
    end

    function automatic int pix(input bit ramp, input int r, input int c);
        return ramp ? (r * 8 + c) : 100;
    endfunction

    // Presents one pixel from a negedge and returns at the negedge after its accept.
    task automatic send_pixel(input bit ramp, input int r, input int c);
        int n = 0;
        exp_t e;
        bus_if.s_valid = 1'b1;
        bus_if.s_data  = pix(ramp, r, c);
        while (!bus_if.s_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            chk_eq("accept_timeout", n, 0);
            aborted = 1'b1;
        end else begin
            if (r >= 4 && c >= 4) begin
                e.row = r - 2; e.col = c - 2;
                e.data = pix(ramp, r - 2, c - 2);
                e.acc = cyc;
                exp_q.push_back(e);
            end
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit ramp);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (!aborted) send_pixel(ramp, r, c);
    endtask

    task automatic wait_drain();
        int n = 0;
        bus_if.s_valid = 1'b0;
        while ((exp_q.size() != 0 || bus_if.m_valid) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk_eq("drain", exp_q.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int n;
        bit found;
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within 40000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;
        int n;
        bit found;
        rst_b = 1'b0;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 8'd0;
        repeat (3) @(negedge clk);
        chk_eq("rst_s_ready", int'(bus_if.s_ready), 0);
        chk_eq("rst_m_valid", int'(bus_if.m_valid), 0);
        chk_eq("rst_bCE", int'(bus_if.bCE), 1);
        chk_eq("rst_bWE", int'(bus_if.bWE), 1);
        chk_eq("rst_bOPEnable", int'(bus_if.bOPEnable), 1);
        chk_eq("rst_addr_row", int'(bus_if.dAddrRegRow), 0);
        chk_eq("rst_addr_col", int'(bus_if.dAddrRegCol), 0);
        chk_eq("rst_InData", int'(bus_if.InData), 0);
        chk_eq("rst_OPMode", int'(bus_if.OPMode), 0);
        chk_eq("rst_dReadReg", int'(bus_if.dReadReg), 0);
        chk_eq("rst_dWriteReg", int'(bus_if.dWriteReg), 0);
        chk_eq("rst_m_data", int'(bus_if.m_data), 0);
        chk_eq("rst_m_row", int'(bus_if.m_row), 0);
        chk_eq("rst_m_col", int'(bus_if.m_col), 0);
        rst_b = 1'b1;
        @(posedge clk); #1;
        chk_eq("s_ready_after_rst", int'(bus_if.s_ready), 1);
        @(negedge clk);

        // Ramp frame: write ordering of first window, backpressure on first output.
        stall_next = 10;
        first_win_chk = 1'b1;
        base = out_cnt;
        send_frame(1'b1);
        wait_drain();
        chk_eq("ramp_outputs", out_cnt - base, 16);

        // Two back-to-back frames (constant 100 then ramp) with s_valid held high.
        base = out_cnt;
        send_frame(1'b0);
        send_frame(1'b1);
        wait_drain();
        chk_eq("wrap_outputs", out_cnt - base, 32);

        // Reset in the middle of a write burst at k=12.
        for (int i = 0; i < 37; i++)
            if (!aborted) send_pixel(1'b1, i / 8, i % 8);
        bus_if.s_valid = 1'b0;
        n = 0;
        found = 1'b0;
        while (!found && n < 100) begin
            if (!bus_if.bCE && !bus_if.bWE &&
                bus_if.dAddrRegRow == 3'd2 && bus_if.dAddrRegCol == 3'd2)
                found = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        chk_eq("k12_reached", int'(found), 1);
        #2 rst_b = 1'b0;
        #1;
        chk_eq("midrst_bCE", int'(bus_if.bCE), 1);
        chk_eq("midrst_bWE", int'(bus_if.bWE), 1);
        chk_eq("midrst_bOPEnable", int'(bus_if.bOPEnable), 1);
        chk_eq("midrst_m_valid", int'(bus_if.m_valid), 0);
        chk_eq("midrst_s_ready", int'(bus_if.s_ready), 0);
        chk_eq("midrst_addr_row", int'(bus_if.dAddrRegRow), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        base = out_cnt;
        send_frame(1'b1);
        wait_drain();
        chk_eq("post_rst_outputs", out_cnt - base, 16);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/canny_window_sequencer.md
# canny_window_sequencer

Streaming front end for the Canny edge core. Accepts a raster pixel stream and builds 5x5 neighbourhoods with four line buffers. For every complete window it writes 25 pixels into the core's regX, runs the Gaussian operation and reads the smoothed result back. It emits one filtered pixel per interior position on a valid/ready output.

## Interface
- DATA_WIDTH, 8, pixel width
- IMG_W, 16, image width in pixels (>=5)
- IMG_H, 16, image height in pixels (>=5)
- COORD_W, 8, width of row/column coordinates (2^COORD_W > max(IMG_W, IMG_H))

Ports:
- clk  in  1  single clock, all logic rising-edge
- rst_b  in  1  asynchronous, active-low reset
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  input pixel, raster order
- m_valid  out  1  filtered pixel valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  filtered pixel
- m_row, m_col  out  COORD_W  centre coordinates of the window
- dAddrRegRow, dAddrRegCol  out  3  core register address
- bWE, bCE  out  1  core write / chip enable, active-low
- InData  out  DATA_WIDTH  core write data
- OutData  in  DATA_WIDTH  core read data
- OPMode  out  3  tied to 0 (Gaussian)
- bOPEnable  out  1  core operation enable, active-low
- dReadReg, dWriteReg  out  4  tied to 0 (Gaussian result / regX)

## Operation
- Counters: `col` runs 0..IMG_W-1 and `row` runs 0..IMG_H-1. Both advance on each accepted pixel. After (IMG_H-1, IMG_W-1) both wrap to (0,0). Line buffers are not cleared on wrap.
- Storage:
  - 4 line buffers of IMG_W pixels.
  - 5x5 window register. Row 0 is the oldest line, col 0 the oldest column. It shifts left on each accept.
- Window complete: an accept with row>=4 and col>=4. Centre is (row-2, col-2), latched into m_row/m_col.
- Other accepts: the pixel is stored and s_ready stays 1.
- FSM states and core-side outputs:
  - IDLE: s_ready=1, bCE=1, bWE=1, bOPEnable=1. Goes to WRITE on a window-complete accept, with k=0.
  - WRITE (k=0..24): bCE=0, bWE=0, dAddrRegRow=k/5, dAddrRegCol=k%5, InData=win[k/5][k%5]. After k=24 goes to OP.
  - OP (2 cycles): bCE=1, bOPEnable=0.
  - CLR (1 cycle): bCE=1, bOPEnable=1. This returns the core's internal phase to its start.
  - READ (1 cycle): bCE=0, bWE=1.
  - CAPT (1 cycle): registers m_data <= OutData.
  - OUT: m_valid=1. On m_ready goes to IDLE.
- s_ready is 0 in every state except IDLE. The window is therefore frozen during a sequence.
- Reset (asynchronous, any state, including mid-sequence):
  - state=IDLE, row=col=0, k=0.
  - m_valid=0, m_data=0, m_row=m_col=0.
  - bCE=1, bWE=1, bOPEnable=1, address=0, InData=0, OPMode=0, dReadReg=0, dWriteReg=0.
  - s_ready=0 while rst_b is low.
  - Line-buffer contents are don't-care. They are never used before being rewritten, because output is gated by row>=4.

## Timing
- Non-window pixels: one accept per cycle.
- Window-complete accept on edge T:
  - WRITE cycles T+1..T+25, OP T+26..T+27, CLR T+28, READ T+29, CAPT T+30.
  - m_valid rises after the edge ending T+30 and is held until m_ready.
  - s_ready returns 1 the cycle after the m_valid && m_ready edge.
- Minimum 31 cycles per output plus the handshake.
- m_data, m_row and m_col are stable while m_valid=1 && m_ready=0.
- Outputs per frame: (IMG_W-4)*(IMG_H-4), with centres rows 2..IMG_H-3 and cols 2..IMG_W-3 in raster order.

## Test plan
- Reset: hold rst_b=0 -> s_ready=0, m_valid=0, bCE=1, bWE=1, bOPEnable=1, all buses 0. After release, s_ready=1 the next cycle.
- Write ordering: 8x8 ramp, pixel=r*8+c. For the first window:
  - k=0 gives addr (0,0), InData=0.
  - k=12 gives addr (2,2), InData=18.
  - k=24 gives addr (4,4), InData=36.
  - bCE/bWE low for exactly 25 cycles.
- End-to-end with the edge core: 8x8 image of constant 100 -> 16 outputs, each m_data=100. m_row/m_col step through (2,2)..(5,5) in raster order. Each m_valid comes 31 cycles after its window-complete accept.
- Backpressure: m_ready=0 for 10 cycles -> m_valid, m_data and coordinates held, s_ready=0 throughout, no core activity. s_ready=1 one cycle after m_ready=1.
- Reset mid-sequence: assert rst_b=0 at k=12 -> core control returns to idle immediately, m_valid=0. The next frame's first output is centred at (2,2).
- Frame wrap: two back-to-back 8x8 frames with s_valid always 1 -> 32 outputs. The second frame's first centre is (2,2), and no output occurs while row<4 of frame 2.
